// File: rtl/fft_stage_sequencer_pkg.sv
// Shared constants for the FFT stage sequencer: default pipeline geometry,
// control-token bit layout and the stage/output offset arithmetic.
package fft_stage_sequencer_pkg;

    localparam int NSTAGE_DEF    = 3;
    localparam int FRAME_CYC_DEF = 16;
    localparam int BF_LAT_DEF    = 2;

    localparam int TOK_VALID = 0;
    localparam int TOK_SOF   = 1;
    localparam int TOK_EOF   = 2;
    localparam int TOK_W     = 3;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } seq_state_t;

    function automatic int stageDepth(input int s);
        return 1 << s;
    endfunction

    // Butterfly, then commutator (2*D_s), repeated until stage s is reached.
    function automatic int startOffset(input int s, input int bfLat);
        int t;
        t = bfLat;
        for (int i = 0; i < s; i++) begin
            t += 2 * stageDepth(i) + bfLat;
        end
        return t;
    endfunction

    function automatic int outLatency(input int nStage, input int bfLat);
        return startOffset(nStage - 1, bfLat) + 2 * stageDepth(nStage - 1) + bfLat;
    endfunction

endpackage

// File: rtl/fft_token_delay.sv
// Fixed-depth shift register of control tokens; every tap is exposed so the
// sequencer can pick stage start pulses off intermediate depths.
module fft_token_delay #(
    parameter int DEPTH = 22,
    parameter int WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       i_din,
    output logic [DEPTH*WIDTH-1:0] o_taps
);

    logic [WIDTH-1:0] r_line [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
            end
        end else begin
            r_line[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_tap
        assign o_taps[k*WIDTH +: WIDTH] = r_line[k];
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for the streaming radix-2 FFT: validates input framing,
// launches each commutator stage and regenerates framing at the output.
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter int NSTAGE    = NSTAGE_DEF,
    parameter int FRAME_CYC = FRAME_CYC_DEF,
    parameter int BF_LAT    = BF_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              err_clr,
    output logic [NSTAGE-1:0] stage_start,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(FRAME_CYC);
    localparam int LAT   = outLatency(NSTAGE, BF_LAT);

    seq_state_t             r_state;
    seq_state_t             w_stateNext;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cntNext;
    logic                   r_err;
    logic                   w_errSet;
    logic [TOK_W-1:0]       w_tokIn;
    logic [LAT*TOK_W-1:0]   w_taps;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            if (w_errSet) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // r_cnt holds the number of groups already accepted in the current frame.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_errSet    = 1'b0;
        w_tokIn     = '0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    w_tokIn[TOK_VALID] = 1'b1;
                    w_tokIn[TOK_SOF]   = 1'b1;
                    w_cntNext          = CNT_W'(1);
                    w_stateNext        = ST_RUN;
                end else if (in_valid) begin
                    w_errSet = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_valid && in_sof) begin
                    w_errSet           = 1'b1;
                    w_tokIn[TOK_VALID] = 1'b1;
                    w_tokIn[TOK_SOF]   = 1'b1;
                    w_cntNext          = CNT_W'(1);
                end else if (in_valid) begin
                    w_tokIn[TOK_VALID] = 1'b1;
                    if (r_cnt == CNT_W'(FRAME_CYC - 1)) begin
                        w_tokIn[TOK_EOF] = 1'b1;
                        w_cntNext        = '0;
                        w_stateNext      = ST_IDLE;
                    end else begin
                        w_cntNext = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_errSet    = 1'b1;
                    w_cntNext   = '0;
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_cntNext   = '0;
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    fft_token_delay #(
        .DEPTH (LAT),
        .WIDTH (TOK_W)
    ) u_tokenDelay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_din   (w_tokIn),
        .o_taps  (w_taps)
    );

    // Tap k becomes visible k+1 cycles after acceptance, hence the -1.
    for (genvar s = 0; s < NSTAGE; s++) begin : g_start
        localparam int T_S = startOffset(s, BF_LAT);
        assign stage_start[s] = w_taps[(T_S-1)*TOK_W + TOK_SOF];
    end

    assign out_valid = w_taps[(LAT-1)*TOK_W + TOK_VALID];
    assign out_sof   = w_taps[(LAT-1)*TOK_W + TOK_SOF];
    assign out_eof   = w_taps[(LAT-1)*TOK_W + TOK_EOF];
    assign err       = r_err;

    // sof/eof never appear without valid, so a plain OR over the line is exact.
    assign busy = (r_state == ST_RUN) | (|w_taps);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: frame-level reference model
// plus directed framing scenarios and a randomized stream.
module tb_fft_stage_sequencer;

    localparam int NST = 3;
    localparam int FC  = 16;
    localparam int BFL = 2;

    logic           clk      = 1'b0;
    logic           reset_n  = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_sof   = 1'b0;
    logic           err_clr  = 1'b0;
    logic [NST-1:0] stage_start;
    logic           out_valid;
    logic           out_sof;
    logic           out_eof;
    logic           busy;
    logic           err;

    fft_stage_sequencer #(
        .NSTAGE    (NST),
        .FRAME_CYC (FC),
        .BF_LAT    (BFL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .err_clr     (err_clr),
        .stage_start (stage_start),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int tOff [NST];
    int latency;

    bit             expValid [int];
    bit             expSof   [int];
    bit             expEof   [int];
    logic [NST-1:0] expStart [int];
    bit             mInFrame;
    int             mPos;
    bit             mErr;
    int             lastAccept;

    int sofSeen [$];
    int eofSeen [$];
    int startSeen [NST][$];
    int validCount;
    int lastBusyCyc;
    int base;

    // Offsets straight from the pipeline description: butterfly, commutator 2*2**s, ...
    function automatic void computeOffsets();
        tOff[0] = BFL;
        for (int s = 1; s < NST; s++) begin
            tOff[s] = tOff[s-1] + 2 * (2 ** (s - 1)) + BFL;
        end
        latency = tOff[NST-1] + 2 * (2 ** (NST - 1)) + BFL;
    endfunction

    function automatic void clearModel();
        expValid.delete();
        expSof.delete();
        expEof.delete();
        expStart.delete();
        mInFrame   = 1'b0;
        mPos       = 0;
        mErr       = 1'b0;
        lastAccept = -100000;
    endfunction

    function automatic void clearObs();
        sofSeen.delete();
        eofSeen.delete();
        for (int s = 0; s < NST; s++) startSeen[s].delete();
        validCount  = 0;
        lastBusyCyc = -1;
    endfunction

    function automatic void addStart(input int c, input int s);
        logic [NST-1:0] v;
        v = expStart.exists(c) ? expStart[c] : '0;
        v[s] = 1'b1;
        expStart[c] = v;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic pinIdx(input string name, input int q[$], input int idx, input int exp);
        int act;
        act = (idx < q.size()) ? q[idx] : -1;
        check1(name, act, exp);
    endtask

    // Compare every output against the model for the current cycle and log events.
    task automatic checkOutput();
        logic [NST-1:0] es;
        bit             expBusy;
        es      = expStart.exists(cyc) ? expStart[cyc] : '0;
        expBusy = mInFrame || ((cyc - lastAccept) >= 1 && (cyc - lastAccept) <= latency);
        check1("stage_start", stage_start, es);
        check1("out_valid", out_valid, expValid.exists(cyc) ? expValid[cyc] : 1'b0);
        check1("out_sof", out_sof, expSof.exists(cyc) ? expSof[cyc] : 1'b0);
        check1("out_eof", out_eof, expEof.exists(cyc) ? expEof[cyc] : 1'b0);
        check1("busy", busy, expBusy);
        check1("err", err, mErr);
        if (out_sof) sofSeen.push_back(cyc);
        if (out_eof) eofSeen.push_back(cyc);
        if (out_valid) validCount++;
        if (busy) lastBusyCyc = cyc;
        for (int s = 0; s < NST; s++) begin
            if (stage_start[s]) startSeen[s].push_back(cyc);
        end
    endtask

    // Frame model: position within frame counts accepted groups, FC-th one carries eof.
    task automatic modelStep(input bit v, input bit s, input bit clr);
        bit errNow;
        bit acc;
        bit isSof;
        bit isEof;
        errNow = 1'b0;
        acc    = 1'b0;
        isSof  = 1'b0;
        isEof  = 1'b0;
        if (v && s) begin
            if (mInFrame) errNow = 1'b1;
            acc      = 1'b1;
            isSof    = 1'b1;
            mInFrame = 1'b1;
            mPos     = 1;
        end else if (v && mInFrame) begin
            acc  = 1'b1;
            mPos = mPos + 1;
            if (mPos == FC) begin
                isEof    = 1'b1;
                mInFrame = 1'b0;
                mPos     = 0;
            end
        end else if (v) begin
            errNow = 1'b1;
        end else if (mInFrame) begin
            errNow   = 1'b1;
            mInFrame = 1'b0;
            mPos     = 0;
        end
        if (acc) begin
            expValid[cyc + latency] = 1'b1;
            lastAccept = cyc;
            if (isSof) begin
                expSof[cyc + latency] = 1'b1;
                for (int k = 0; k < NST; k++) addStart(cyc + tOff[k], k);
            end
            if (isEof) expEof[cyc + latency] = 1'b1;
        end
        if (errNow) mErr = 1'b1;
        else if (clr) mErr = 1'b0;
    endtask

    task automatic applyStimulus(input bit v, input bit s, input bit clr);
        @(posedge clk);
        #1;
        cyc++;
        in_valid = v;
        in_sof   = s;
        err_clr  = clr;
        @(negedge clk);
        checkOutput();
        modelStep(v, s, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        #1;
        clearModel();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        err_clr  = 1'b0;
        checkOutput();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic sendFrame(input int n);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (n - 1) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        computeOffsets();
        clearModel();
        clearObs();
        #2;
        doReset();
        idle(2);

        // Single clean frame
        clearObs();
        base = cyc + 1;
        sendFrame(FC);
        idle(30);
        pinIdx("t1_out_sof", sofSeen, 0, base + 22);
        pinIdx("t1_out_eof", eofSeen, 0, base + 37);
        pinIdx("t1_start0", startSeen[0], 0, base + 2);
        pinIdx("t1_start1", startSeen[1], 0, base + 6);
        pinIdx("t1_start2", startSeen[2], 0, base + 12);
        check1("t1_valid_count", validCount, 16);
        check1("t1_busy_last", lastBusyCyc, base + 37);
        check1("t1_err", err, 1'b0);

        // Two back-to-back frames
        clearObs();
        base = cyc + 1;
        sendFrame(FC);
        sendFrame(FC);
        idle(30);
        pinIdx("t2_out_sof2", sofSeen, 1, base + 38);
        pinIdx("t2_out_eof2", eofSeen, 1, base + 53);
        check1("t2_valid_count", validCount, 32);
        for (int s = 0; s < NST; s++) check1("t2_start_count", startSeen[s].size(), 2);

        // Gap after five groups
        clearObs();
        base = cyc + 1;
        sendFrame(5);
        applyStimulus(1'b0, 1'b0, 1'b0);
        idle(30);
        check1("t3_valid_count", validCount, 5);
        check1("t3_eof_count", eofSeen.size(), 0);
        check1("t3_err", err, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(1);
        check1("t3_err_cleared", err, 1'b0);

        // Early sof at position 8 restarts the frame
        clearObs();
        base = cyc + 1;
        sendFrame(8);
        sendFrame(FC);
        idle(30);
        pinIdx("t4_out_sof1", sofSeen, 0, base + 22);
        pinIdx("t4_out_sof2", sofSeen, 1, base + 30);
        pinIdx("t4_out_eof", eofSeen, 0, base + 45);
        check1("t4_eof_count", eofSeen.size(), 1);
        check1("t4_err", err, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(2);

        // Valid without sof while idle; clear racing a new error
        clearObs();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        idle(1);
        check1("t5_err_set_wins", err, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(1);
        check1("t5_err_clr", err, 1'b0);
        idle(25);
        check1("t5_valid_count", validCount, 0);
        check1("t5_busy_never", lastBusyCyc, -1);

        // Reset mid-frame at position 10
        sendFrame(10);
        @(posedge clk);
        #1;
        cyc++;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        reset_n  = 1'b0;
        #1;
        check1("t6_start_zero", stage_start, 0);
        check1("t6_busy_zero", busy, 1'b0);
        check1("t6_valid_zero", out_valid, 1'b0);
        doReset();
        clearObs();
        idle(30);
        check1("t6_valid_after", validCount, 0);
        for (int s = 0; s < NST; s++) check1("t6_start_after", startSeen[s].size(), 0);

        // Randomized stream
        for (int i = 0; i < 1500; i++) begin
            bit v;
            bit s;
            bit c;
            v = ($urandom_range(0, 99) < 92);
            s = mInFrame ? ($urandom_range(0, 99) < 4) : ($urandom_range(0, 99) < 60);
            c = ($urandom_range(0, 99) < 8);
            applyStimulus(v, s, c);
        end
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
